// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// It accepts one operation per valid/ready handshake and runs one radix-2 step
// per clock. Results come back with a one-cycle done_o pulse and a tag.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   valid_i, ready_o  request handshake; accepted when valid_i & ready_o & !flush_i
//   funct3_i          0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a_i, op_b_i    rs1 / rs2 operands
//   tag_i, tag_o      pass-through tag (destination register)
//   flush_i           abort the in-flight operation
//   busy_o            high while iterating (drives pipeline stall)
//   done_o            one-cycle result-valid pulse
//   result_o          result, held until the next done_o
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [2:0]          op_r;
  logic                neg_r;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     operand_r;
  logic [TAG_W-1:0]    tag_r;

  logic                accept;
  logic                is_div_in, sign_a_in, sign_b_in, neg_in;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res;

  logic [XLEN:0]       mul_sum, div_shifted, div_diff;
  logic                q_bit;
  logic [XLEN-1:0]     rem_next;
  logic [2*XLEN-1:0]   step_next;
  logic [XLEN-1:0]     hi_neg, div_sel, final_res;

  assign ready_o = (state == IDLE) || (state == DONE);
  assign busy_o  = (state == CALC);
  assign done_o  = (state == DONE);
  assign accept  = valid_i & ready_o & ~flush_i;

  // Request decode: signed operands are turned into magnitudes up front so the
  // iteration is purely unsigned; the result sign is applied on the last step.
  // MULHSU treats only operand A as signed. REM results follow the dividend.
  always_comb begin
    is_div_in = funct3_i[2];
    sign_a_in = op_a_i[XLEN-1] &
                ((funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i == 3'd4) | (funct3_i == 3'd6));
    sign_b_in = op_b_i[XLEN-1] &
                ((funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6));
    mag_a     = sign_a_in ? -op_a_i : op_a_i;
    mag_b     = sign_b_in ? -op_b_i : op_b_i;
    neg_in    = (funct3_i[2] & funct3_i[1]) ? sign_a_in : (sign_a_in ^ sign_b_in);
    div_zero  = is_div_in & (op_b_i == '0);
    div_ovf   = is_div_in & ~funct3_i[0] &
                (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
    // Corner cases resolved without iterating.
    if (div_zero)
      fast_res = funct3_i[1] ? op_a_i : '1;
    else
      fast_res = funct3_i[1] ? '0 : op_a_i;
  end

  // One iteration step. Multiply: acc = {partial high, remaining multiplier},
  // add the multiplicand when the multiplier LSB is set and shift right.
  // Divide: acc = {partial remainder, dividend/quotient}, restoring subtract.
  always_comb begin
    mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_r} : '0);
    div_shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff    = div_shifted - {1'b0, operand_r};
    q_bit       = ~div_diff[XLEN];
    rem_next    = q_bit ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
    if (op_r[2])
      step_next = {rem_next, acc[XLEN-2:0], q_bit};
    else
      step_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign correction of the final step. Negating a 2*XLEN product only needs
  // the high half: ~hi plus a carry when the low half is zero.
  always_comb begin
    hi_neg  = ~step_next[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (step_next[XLEN-1:0] == '0)};
    div_sel = op_r[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    if (op_r[2])
      final_res = neg_r ? -div_sel : div_sel;
    else if (op_r[1:0] == 2'd0)
      final_res = step_next[XLEN-1:0];
    else
      final_res = neg_r ? hi_neg : step_next[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers. A request may be taken in IDLE or in
  // the DONE cycle; flush aborts CALC without touching result_o/tag_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= '0;
      op_r      <= '0;
      neg_r     <= 1'b0;
      acc       <= '0;
      operand_r <= '0;
      tag_r     <= '0;
      result_o  <= '0;
      tag_o     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_r  <= funct3_i;
            neg_r <= neg_in;
            tag_r <= tag_i;
            if (div_zero || div_ovf) begin
              result_o <= fast_res;
              tag_o    <= tag_i;
              state    <= DONE;
            end else begin
              acc       <= is_div_in ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
              operand_r <= is_div_in ? mag_b : mag_a;
              count     <= CNT_W'(XLEN - 1);
              state     <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (flush_i) begin
            count <= '0;
            state <= IDLE;
          end else begin
            acc <= step_next;
            if (count == '0) begin
              result_o <= final_res;
              tag_o    <= tag_r;
              state    <= DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (XLEN=32). Expected results are queued when a
// request is driven and compared when done_o is observed.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  op_a_i, op_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             busy_o, done_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          assertions = 0;
  int          failures   = 0;
  logic [31:0] last_result = '0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model built from native wide arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] as_, bs_;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    as_ = a;
    bs_ = b;
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return as_ / bs_;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return as_ % bs_;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Drives a request until it is accepted; optionally queues the expectation.
  // Returns #1 after the accepting edge (cycle 1 of the operation).
  task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] er, input int el, input bit push);
    bit   accepted = 0;
    int   i = 0;
    exp_t e;
    valid_i  = 1'b1;
    funct3_i = f;
    op_a_i   = a;
    op_b_i   = b;
    tag_i    = t;
    while (i < 100 && !accepted) begin
      @(negedge clk_i);
      if (ready_o && !flush_i) accepted = 1;
      @(posedge clk_i);
      #1;
      i++;
    end
    valid_i = 1'b0;
    if (!accepted) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: ready_o never seen, required acceptance within 100 cycles");
    end else if (push) begin
      e.res = er;
      e.tag = t;
      e.lat = el;
      sb_q.push_back(e);
    end
  endtask

  // Waits (bounded) for done_o; lat is the cycle index of done_o after acceptance.
  task automatic wait_done(output bit seen, output int lat, output int busy_cnt);
    int n = 1;
    seen = 0;
    lat = 0;
    busy_cnt = 0;
    while (n <= 200 && !seen) begin
      if (done_o) begin
        seen = 1;
        lat  = n;
      end else begin
        if (busy_o) busy_cnt++;
        @(posedge clk_i);
        #1;
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = '0;
    op_a_i   = '0;
    op_b_i   = '0;
    tag_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    assertions++;
    if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b, expected 1", ready_o); end
    assertions++;
    if ({busy_o, done_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_busy_done: got %b, expected 00", {busy_o, done_o}); end
    assertions++;
    if (result_o !== '0 || tag_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_result_tag: got %h/%h, expected 0/0", result_o, tag_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_mul();
    logic [2:0]  tf[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] ta[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] te[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    bit seen;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue_op(tf[i], ta[i], tb[i], 5'(i + 3), te[i], 33, 1);
      if (i == 0) begin
        assertions++;
        if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL mul_busy_cycle1: got %b, expected 1", busy_o); end
      end
      wait_done(seen, lat, bc);
      if (i == 0) begin
        assertions++;
        if (bc !== 32) begin failures++; $display("[TB] FAIL mul_busy_cycles: got %0d, expected 32", bc); end
      end
      assertions++;
      if (!seen || sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL mul_done[%0d]: done seen %0b, queued %0d, expected done with queued result", i, seen, sb_q.size());
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
        e = sb_q.pop_front();
        assertions++;
        if (result_o !== e.res) begin failures++; $display("[TB] FAIL mul_result[%0d]: got %h, expected %h", i, result_o, e.res); end
        assertions++;
        if (tag_o !== e.tag) begin failures++; $display("[TB] FAIL mul_tag[%0d]: got %h, expected %h", i, tag_o, e.tag); end
        assertions++;
        if (lat !== e.lat) begin failures++; $display("[TB] FAIL mul_latency[%0d]: got %0d, expected %0d", i, lat, e.lat); end
        last_result = e.res;
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] tb[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] te[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    bit seen;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue_op(tf[i], ta[i], tb[i], 5'(i + 10), te[i], 33, 1);
      wait_done(seen, lat, bc);
      assertions++;
      if (!seen || sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL div_done[%0d]: done seen %0b, queued %0d, expected done with queued result", i, seen, sb_q.size());
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
        e = sb_q.pop_front();
        assertions++;
        if (result_o !== e.res) begin failures++; $display("[TB] FAIL div_result[%0d]: got %h, expected %h", i, result_o, e.res); end
        assertions++;
        if (tag_o !== e.tag) begin failures++; $display("[TB] FAIL div_tag[%0d]: got %h, expected %h", i, tag_o, e.tag); end
        assertions++;
        if (lat !== e.lat) begin failures++; $display("[TB] FAIL div_latency[%0d]: got %0d, expected %0d", i, lat, e.lat); end
        last_result = e.res;
      end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  tf[6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] ta[6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] tb[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] te[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
    bit seen;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue_op(tf[i], ta[i], tb[i], 5'(i + 20), te[i], 1, 1);
      wait_done(seen, lat, bc);
      assertions++;
      if (!seen || sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL fast_done[%0d]: done seen %0b, queued %0d, expected done with queued result", i, seen, sb_q.size());
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
        e = sb_q.pop_front();
        assertions++;
        if (result_o !== e.res) begin failures++; $display("[TB] FAIL fast_result[%0d]: got %h, expected %h", i, result_o, e.res); end
        assertions++;
        if (tag_o !== e.tag) begin failures++; $display("[TB] FAIL fast_tag[%0d]: got %h, expected %h", i, tag_o, e.tag); end
        assertions++;
        if (lat !== e.lat) begin failures++; $display("[TB] FAIL fast_latency[%0d]: got %0d, expected %0d", i, lat, e.lat); end
        last_result = e.res;
      end
    end
  endtask

  task automatic test_flush();
    int done_cnt = 0;
    issue_op(3'd4, 32'd1000, 32'd3, 5'd30, 32'd0, 33, 0);
    repeat (9) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    assertions++;
    if ({ready_o, busy_o, done_o} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL flush_state: ready/busy/done got %b, expected 100", {ready_o, busy_o, done_o});
    end
    assertions++;
    if (result_o !== last_result) begin failures++; $display("[TB] FAIL flush_result_held: got %h, expected %h", result_o, last_result); end
    repeat (40) begin
      if (done_o) done_cnt++;
      @(posedge clk_i);
      #1;
    end
    assertions++;
    if (done_cnt !== 0) begin failures++; $display("[TB] FAIL flush_no_done: got %0d pulses, expected 0", done_cnt); end
    // A flush in IDLE blocks a same-cycle request.
    valid_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'd5;
    op_a_i   = 32'd9;
    op_b_i   = 32'd3;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    assertions++;
    if ({ready_o, busy_o, done_o} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL flush_blocks_accept: ready/busy/done got %b, expected 100", {ready_o, busy_o, done_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a, b;
    bit seen;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        f = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      end else if (i == 1) begin
        f = 3'd5; a = 32'd100; b = 32'd7;
      end else begin
        f = 3'($urandom_range(0, 7));
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      end
      // Each new request is driven during the previous DONE cycle.
      issue_op(f, a, b, 5'($urandom), ref_model(f, a, b), ref_latency(f, a, b), 1);
      wait_done(seen, lat, bc);
      assertions++;
      if (!seen || sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_done[%0d]: done seen %0b, queued %0d, expected done with queued result", i, seen, sb_q.size());
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
        e = sb_q.pop_front();
        assertions++;
        if (result_o !== e.res) begin
          failures++;
          $display("[TB] FAIL b2b_result[%0d] f=%0d a=%h b=%h: got %h, expected %h", i, f, a, b, result_o, e.res);
        end
        assertions++;
        if (tag_o !== e.tag) begin failures++; $display("[TB] FAIL b2b_tag[%0d]: got %h, expected %h", i, tag_o, e.tag); end
        assertions++;
        if (lat !== e.lat) begin failures++; $display("[TB] FAIL b2b_latency[%0d]: got %0d, expected %0d", i, lat, e.lat); end
        last_result = e.res;
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    int lat, bc;
    exp_t e;
    issue_op(3'd0, 32'd3, 32'd5, 5'd17, 32'd0, 33, 0);
    repeat (5) @(posedge clk_i);
    #4;
    rst_i = 1'b1;
    #1;
    assertions++;
    if ({ready_o, busy_o, done_o} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL async_reset_state: ready/busy/done got %b, expected 100", {ready_o, busy_o, done_o});
    end
    assertions++;
    if (result_o !== '0 || tag_o !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset_result_tag: got %h/%h, expected 0/0", result_o, tag_o);
    end
    #2;
    rst_i = 1'b0;
    last_result = '0;
    @(posedge clk_i);
    #1;
    issue_op(3'd0, 32'd6, 32'd7, 5'd9, 32'd42, 33, 1);
    wait_done(seen, lat, bc);
    assertions++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL post_reset_done: done seen %0b, queued %0d, expected done with queued result", seen, sb_q.size());
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      assertions++;
      if (result_o !== e.res || tag_o !== e.tag || lat !== e.lat) begin
        failures++;
        $display("[TB] FAIL post_reset_op: got %h/%h/%0d, expected %h/%h/%0d", result_o, tag_o, lat, e.res, e.tag, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
